// File: rtl/siren_monitor.sv
// Protocol checker for the alarm siren tone generator: watches the 3-bit tone code
// against enable_siren / two_hz_enable, latches the first violation as a coded fault.
module siren_monitor #(
    parameter int unsigned START_TIMEOUT = 4,
    parameter int unsigned STOP_TIMEOUT  = 4,
    parameter int unsigned MAX_TICKS     = 2
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       enable_siren,
    input  logic       two_hz_enable,
    input  logic [2:0] siren,
    input  logic       clear_fault,
    output logic       active,
    output logic       fault,
    output logic [2:0] fault_code,
    output logic [7:0] toggle_count,
    output logic [2:0] state
);

    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_WAIT_START = 3'd1,
        S_LOW_TONE   = 3'd2,
        S_HIGH_TONE  = 3'd3,
        S_STOP_WAIT  = 3'd4,
        S_FAULT      = 3'd5
    } state_t;

    localparam logic [2:0] TONE_OFF  = 3'd0;
    localparam logic [2:0] TONE_LOW  = 3'd1;
    localparam logic [2:0] TONE_HIGH = 3'd4;

    localparam logic [2:0] CODE_NONE     = 3'd0;
    localparam logic [2:0] CODE_START    = 3'd1;
    localparam logic [2:0] CODE_ILLEGAL  = 3'd2;
    localparam logic [2:0] CODE_STUCK    = 3'd3;
    localparam logic [2:0] CODE_STOP     = 3'd4;
    localparam logic [2:0] CODE_SPURIOUS = 3'd5;

    // Timers compare against the last allowed count, so a timeout of N fails on the Nth cycle.
    localparam logic [7:0] START_LAST = 8'(START_TIMEOUT - 1);
    localparam logic [7:0] STOP_LAST  = 8'(STOP_TIMEOUT - 1);
    localparam logic [3:0] TICK_LIMIT = 4'(MAX_TICKS);

    state_t     state_q, state_d;
    logic [7:0] timer_q, timer_d;
    logic [3:0] tick_q, tick_d;
    logic [7:0] toggle_q, toggle_d;
    logic [2:0] code_q, code_d;

    logic [2:0] own_tone;
    logic [2:0] other_tone;
    state_t     other_state;

    assign own_tone    = (state_q == S_HIGH_TONE) ? TONE_HIGH : TONE_LOW;
    assign other_tone  = (state_q == S_HIGH_TONE) ? TONE_LOW : TONE_HIGH;
    assign other_state = (state_q == S_HIGH_TONE) ? S_LOW_TONE : S_HIGH_TONE;

    // State and datapath registers
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            timer_q  <= 8'd0;
            tick_q   <= 4'd0;
            toggle_q <= 8'd0;
            code_q   <= CODE_NONE;
        end else begin
            state_q  <= state_d;
            timer_q  <= timer_d;
            tick_q   <= tick_d;
            toggle_q <= toggle_d;
            code_q   <= code_d;
        end
    end

    // Next-state and datapath update; branch order encodes the per-cycle priority
    always_comb begin
        state_d  = state_q;
        timer_d  = timer_q;
        tick_d   = tick_q;
        toggle_d = toggle_q;
        code_d   = code_q;
        case (state_q)
            S_IDLE: begin
                if (enable_siren) begin
                    state_d  = S_WAIT_START;
                    toggle_d = 8'd0;
                    timer_d  = 8'd0;
                end else if (siren != TONE_OFF) begin
                    state_d = S_FAULT;
                    code_d  = CODE_SPURIOUS;
                end
            end
            S_WAIT_START: begin
                if (!enable_siren) begin
                    state_d = S_STOP_WAIT;
                    timer_d = 8'd0;
                end else if (siren == TONE_LOW) begin
                    state_d = S_LOW_TONE;
                    tick_d  = 4'd0;
                end else if (siren != TONE_OFF) begin
                    state_d = S_FAULT;
                    code_d  = CODE_ILLEGAL;
                end else if (timer_q == START_LAST) begin
                    state_d = S_FAULT;
                    code_d  = CODE_START;
                end else begin
                    timer_d = timer_q + 8'd1;
                end
            end
            S_LOW_TONE, S_HIGH_TONE: begin
                if (!enable_siren) begin
                    state_d = S_STOP_WAIT;
                    timer_d = 8'd0;
                end else if (siren == other_tone) begin
                    // A change coinciding with a tick still counts as a toggle.
                    state_d  = other_state;
                    tick_d   = 4'd0;
                    toggle_d = (toggle_q == 8'hFF) ? toggle_q : toggle_q + 8'd1;
                end else if (siren == own_tone) begin
                    if (two_hz_enable) begin
                        if (tick_q + 4'd1 == TICK_LIMIT) begin
                            state_d = S_FAULT;
                            code_d  = CODE_STUCK;
                        end else begin
                            tick_d = tick_q + 4'd1;
                        end
                    end
                end else begin
                    state_d = S_FAULT;
                    code_d  = CODE_ILLEGAL;
                end
            end
            S_STOP_WAIT: begin
                if (siren == TONE_OFF) begin
                    state_d = S_IDLE;
                end else if (siren == TONE_LOW || siren == TONE_HIGH) begin
                    if (timer_q == STOP_LAST) begin
                        state_d = S_FAULT;
                        code_d  = CODE_STOP;
                    end else begin
                        timer_d = timer_q + 8'd1;
                    end
                end else begin
                    state_d = S_FAULT;
                    code_d  = CODE_ILLEGAL;
                end
            end
            S_FAULT: begin
                if (clear_fault) begin
                    state_d = S_IDLE;
                    code_d  = CODE_NONE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Outputs decoded from registered state only
    always_comb begin
        active = 1'b0;
        fault  = 1'b0;
        case (state_q)
            S_LOW_TONE, S_HIGH_TONE: active = 1'b1;
            S_FAULT:                 fault  = 1'b1;
            default: begin
                active = 1'b0;
                fault  = 1'b0;
            end
        endcase
    end

    assign fault_code   = code_q;
    assign toggle_count = toggle_q;
    assign state        = state_q;

endmodule

// File: tb/tb_siren_monitor.sv
// Bench for siren_monitor: directed protocol scenarios followed by random traffic,
// all checked every cycle against a rule-level model of the alarm protocol.
module tb_siren_monitor;

    localparam int START_TO = 4;
    localparam int STOP_TO  = 4;
    localparam int MAXT     = 2;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       en    = 1'b0;
    logic       tk    = 1'b0;
    logic [2:0] sr    = 3'd0;
    logic       clr   = 1'b0;
    logic       active;
    logic       fault;
    logic [2:0] fault_code;
    logic [7:0] toggle_count;
    logic [2:0] dbg_state;

    int checks = 0;
    int errors = 0;

    // model of the protocol
    string ph;
    int    m_tmr, m_ticks, m_tog, m_code;

    siren_monitor #(
        .START_TIMEOUT(START_TO),
        .STOP_TIMEOUT (STOP_TO),
        .MAX_TICKS    (MAXT)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .enable_siren (en),
        .two_hz_enable(tk),
        .siren        (sr),
        .clear_fault  (clr),
        .active       (active),
        .fault        (fault),
        .fault_code   (fault_code),
        .toggle_count (toggle_count),
        .state        (dbg_state)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        ph = "idle"; m_tmr = 0; m_ticks = 0; m_tog = 0; m_code = 0;
    endtask

    task automatic go_fault(input int code);
        ph = "fault";
        m_code = code;
    endtask

    task automatic model_step();
        int own, other;
        if (ph == "idle") begin
            if (en) begin ph = "wait"; m_tog = 0; m_tmr = 0; end
            else if (sr != 0) go_fault(5);
        end else if (ph == "wait") begin
            if (!en) begin ph = "stop"; m_tmr = 0; end
            else if (sr == 1) begin ph = "low"; m_ticks = 0; end
            else if (sr != 0) go_fault(2);
            else if (m_tmr == START_TO - 1) go_fault(1);
            else m_tmr++;
        end else if (ph == "low" || ph == "high") begin
            own   = (ph == "low") ? 1 : 4;
            other = (ph == "low") ? 4 : 1;
            if (!en) begin ph = "stop"; m_tmr = 0; end
            else if (int'(sr) == other) begin
                ph = (ph == "low") ? "high" : "low";
                m_tog = (m_tog + 1 > 255) ? 255 : m_tog + 1;
                m_ticks = 0;
            end else if (int'(sr) == own) begin
                if (tk) begin
                    if (m_ticks + 1 >= MAXT) go_fault(3);
                    else m_ticks++;
                end
            end else go_fault(2);
        end else if (ph == "stop") begin
            if (sr == 0) ph = "idle";
            else if (sr == 1 || sr == 4) begin
                if (m_tmr == STOP_TO - 1) go_fault(4);
                else m_tmr++;
            end else go_fault(2);
        end else if (ph == "fault") begin
            if (clr) begin ph = "idle"; m_code = 0; end
        end
    endtask

    task automatic check_outputs();
        check("active", 32'(active), 32'((ph == "low" || ph == "high") ? 1 : 0));
        check("fault", 32'(fault), 32'((ph == "fault") ? 1 : 0));
        check("fault_code", 32'(fault_code), 32'(m_code));
        check("toggle_count", 32'(toggle_count), 32'(m_tog));
    endtask

    task automatic step();
        @(posedge clock);
        #1;
        model_step();
        check_outputs();
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b0;
        #1;
        model_reset();
        check("rst_active", 32'(active), 32'd0);
        check("rst_fault", 32'(fault), 32'd0);
        check("rst_code", 32'(fault_code), 32'd0);
        check("rst_toggles", 32'(toggle_count), 32'd0);
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset = 1'b1;
    endtask

    initial begin
        logic [2:0] legal[3];
        legal[0] = 3'd0; legal[1] = 3'd1; legal[2] = 3'd4;
        model_reset();

        // nominal alarm with five toggles
        do_reset();
        en = 1; step();
        step();
        sr = 3'd1; step();
        check("nom_active_after_start", 32'(active), 32'd1);
        for (int k = 0; k < 5; k++) begin
            tk = 1; step();
            tk = 0; sr = (sr == 3'd1) ? 3'd4 : 3'd1; step();
        end
        en = 0; step();
        sr = 3'd0; step();
        check("nom_toggles", 32'(toggle_count), 32'd5);
        check("nom_idle_active", 32'(active), 32'd0);
        check("nom_no_fault", 32'(fault), 32'd0);

        // stuck tone across two ticks
        en = 1; step();
        sr = 3'd1; step();
        tk = 1; step();
        tk = 0; step();
        tk = 1; step();
        tk = 0;
        check("stuck_fault", 32'(fault), 32'd1);
        check("stuck_code", 32'(fault_code), 32'd3);
        check("stuck_active", 32'(active), 32'd0);
        clr = 1; en = 0; sr = 3'd0; step();
        clr = 0;

        // start timeout
        en = 1; step();
        repeat (4) step();
        check("start_to_code", 32'(fault_code), 32'd1);
        clr = 1; en = 0; step();
        clr = 0;

        // stop timeout after reset
        do_reset();
        en = 1; step();
        sr = 3'd1; step();
        sr = 3'd4; step();
        en = 0; step();
        repeat (3) step();
        check("stop_not_yet", 32'(fault), 32'd0);
        step();
        check("stop_to_code", 32'(fault_code), 32'd4);

        // illegal code during high tone
        clr = 1; sr = 3'd0; step();
        clr = 0; en = 1; step();
        sr = 3'd1; step();
        sr = 3'd4; step();
        sr = 3'd3; step();
        check("illegal_code", 32'(fault_code), 32'd2);

        // spurious tone while idle, then clear racing a new violation
        clr = 1; en = 0; sr = 3'd0; step();
        clr = 0; sr = 3'd1; step();
        check("spurious_code", 32'(fault_code), 32'd5);
        clr = 1; step();
        check("clear_race_zero", 32'(fault_code), 32'd0);
        clr = 0; step();
        check("clear_race_new", 32'(fault_code), 32'd5);

        // saturation, then asynchronous reset mid-alarm
        clr = 1; sr = 3'd0; step();
        clr = 0; en = 1; step();
        sr = 3'd1; step();
        for (int k = 0; k < 300; k++) begin
            sr = (sr == 3'd1) ? 3'd4 : 3'd1;
            step();
        end
        check("sat_toggles", 32'(toggle_count), 32'd255);
        @(negedge clock);
        #2;
        reset = 1'b0;
        #1;
        model_reset();
        check("async_active", 32'(active), 32'd0);
        check("async_fault", 32'(fault), 32'd0);
        check("async_code", 32'(fault_code), 32'd0);
        check("async_toggles", 32'(toggle_count), 32'd0);
        sr = 3'd0;
        @(negedge clock);
        reset = 1'b1;
        step();
        check("rearm_toggles", 32'(toggle_count), 32'd0);
        sr = 3'd1; step();
        check("rearm_active", 32'(active), 32'd1);

        // random traffic against the model
        do_reset();
        en = 0; tk = 0; sr = 3'd0; clr = 0;
        for (int n = 0; n < 3000; n++) begin
            int r;
            if ($urandom_range(0, 24) == 0) en = ~en;
            tk  = ($urandom_range(0, 5) == 0);
            clr = ($urandom_range(0, 9) == 0);
            r = $urandom_range(0, 99);
            if (r < 4) sr = 3'($urandom_range(0, 7));
            else if (r < 30) sr = legal[$urandom_range(0, 2)];
            else if (r < 50 && en && sr == 3'd0) sr = 3'd1;
            else if (r < 70 && en && sr == 3'd1) sr = 3'd4;
            else if (r < 90 && en && sr == 3'd4) sr = 3'd1;
            else if (!en && r < 60) sr = 3'd0;
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/siren_monitor.md
# siren_monitor

Checks the 3-bit siren tone code produced by the siren generator against the alarm protocol. The protocol: after `enable_siren` rises, the code must switch to 3'd1, alternate 1↔4 on `two_hz_enable` ticks, and return to 3'd0 once `enable_siren` falls. The block sits beside the generator in the alarm subsystem, sees the same `enable_siren` and `two_hz_enable`, and raises a sticky, coded fault on any protocol violation. It also counts completed tone toggles for status display.

## Interface
- START_TIMEOUT, 4: max clock cycles from start of WAIT_START until siren==3'd1.
- STOP_TIMEOUT, 4: max clock cycles from start of STOP_WAIT until siren==3'd0.
- MAX_TICKS, 2: `two_hz_enable` ticks without a tone change that constitute a stuck tone.
- clock  in  1  system clock, all logic on rising edge.
- reset  in  1  asynchronous, active-low reset.
- enable_siren  in  1  alarm request level, same signal fed to the generator.
- two_hz_enable  in  1  one-cycle 2 Hz tick.
- siren  in  3  tone code under test; legal values are 0, 1 and 4.
- clear_fault  in  1  one-cycle pulse, releases FAULT.
- active  out  1  high in LOW_TONE/HIGH_TONE.
- fault  out  1  high in FAULT.
- fault_code  out  3  0 none, 1 START, 2 ILLEGAL, 3 STUCK, 4 STOP, 5 SPURIOUS.
- toggle_count  out  8  completed 1↔4 changes since last start, saturates at 255.

## Operation
- States: IDLE, WAIT_START, LOW_TONE, HIGH_TONE, STOP_WAIT, FAULT.
- IDLE
  - enable_siren==1 → WAIT_START; toggle_count←0; timer←0.
  - Otherwise, siren!=0 → FAULT, code 5.
- WAIT_START
  - enable_siren==0 → STOP_WAIT.
  - siren==1 → LOW_TONE.
  - siren==4, 2, 3, 5, 6 or 7 → FAULT, code 2.
  - siren==0 with timer==START_TIMEOUT-1 → FAULT, code 1.
  - Otherwise timer++.
- LOW_TONE / HIGH_TONE
  - enable_siren==0 → STOP_WAIT; timer←0.
  - siren equals the other tone (4 in LOW, 1 in HIGH) → other tone state; toggle_count++ (saturating); tick_cnt←0.
  - siren equals its own tone: on a tick, tick_cnt++. When tick_cnt would reach MAX_TICKS → FAULT, code 3.
  - Any other siren value, including 0, → FAULT, code 2.
- STOP_WAIT
  - siren==0 → IDLE.
  - siren==1 or 4 with timer==STOP_TIMEOUT-1 → FAULT, code 4; otherwise timer++.
  - Any other value → FAULT, code 2.
  - enable_siren re-rising is ignored until IDLE is reached.
- FAULT
  - Sticky; fault_code holds the first cause.
  - clear_fault → IDLE with fault_code←0. Enable level is re-evaluated from IDLE on the following cycle.
- Priority within a cycle: reset > clear_fault > enable_siren falling > code checks > tick counting.
- A tone change in the same cycle as a tick counts as a toggle; tick_cnt←0.
- Arithmetic
  - timer is 8 bits, so timeout parameters must be ≤255.
  - tick_cnt is 4 bits, so MAX_TICKS must be in 1..15.
  - toggle_count saturates at 255 and does not wrap.

## Timing
- All inputs are sampled on the rising edge of clock.
- All outputs are registered and reflect the state decided at that edge. Latency from a sampled violation to fault=1 is one cycle.
- reset==0, asserted at any time, including mid-alarm or in FAULT:
  - state→IDLE;
  - active=0, fault=0, fault_code=0, toggle_count=0;
  - timers and tick_cnt cleared.
- After reset deasserts, the first evaluation happens on the next rising edge.
- Generator alignment: the tone code changes one cycle after the tick edge. The monitor accepts the change on that cycle; tick_cnt has reached 1 and is then reset.
- clear_fault outside FAULT has no effect.

## Test plan
- Nominal alarm, MAX_TICKS=2:
  - enable_siren=1; siren=1 two cycles later; then siren alternates 1/4 one cycle after each of 5 ticks; enable_siren=0; siren=0 one cycle later.
  - Required: active=1 from the cycle after siren=1; toggle_count=5; returns to IDLE; fault=0 throughout.
- Stuck tone:
  - After start, hold siren=1 across 2 ticks.
  - Required: fault=1 and fault_code=3 on the cycle after the 2nd tick edge; active=0.
- Start and stop timeouts:
  - Start: enable_siren=1 with siren held 0 for 4 cycles → fault_code=1.
  - Stop (after reset): complete a normal start, drop enable_siren, keep siren=4 for 4 cycles → fault_code=4.
- Illegal and spurious codes:
  - siren=3 during HIGH_TONE → fault_code=2.
  - After clear_fault with enable_siren=0, set siren=1 → fault_code=5.
  - clear_fault in the same cycle as a new violation → fault_code=0 for one cycle, then the new code.
- Reset mid-alarm and saturation:
  - Force 300 toggles → toggle_count=255.
  - Pull reset low asynchronously between edges → all outputs 0 immediately.
  - Release reset with enable_siren=1 → re-enters WAIT_START with toggle_count=0.
